// File: rtl/mem_burst_pkg.sv
// ============================================================================
//  Module   : mem_burst_pkg
//  Purpose  : Shared state encoding, default parameters and width helper
//             for the burst memory controller.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package mem_burst_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRITE  = 2'd1,
        ST_READ   = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    localparam int DEF_DATA_W     = 32;
    localparam int DEF_ADDR_W     = 24;
    localparam int DEF_LEN_W      = 8;
    localparam int DEF_FIFO_DEPTH = 16;
    localparam int DEF_TIMEOUT    = 1024;

    // Number of bits needed to index 'value' distinct items.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
//  Module   : sync_fifo
//  Purpose  : Single-clock write-data FIFO with flush and occupancy count.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module sync_fifo
    import mem_burst_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    localparam int PTR_W     = clog2(FIFO_DEPTH),
    localparam int CNT_W     = clog2(FIFO_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic              i_flush,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_full,
    output logic              o_empty,
    output logic [DATA_W-1:0] o_head,
    output logic [CNT_W-1:0]  o_count
);

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_do_push;
    logic              w_do_pop;

    assign o_full    = (r_count == CNT_W'(FIFO_DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_head    = r_mem[r_rd_ptr];
    assign o_count   = r_count;
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // A flush discards stored words but keeps a word pushed in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= r_wr_ptr;
            r_wr_ptr <= r_wr_ptr + PTR_W'(w_do_push);
            r_count  <= CNT_W'(w_do_push);
        end else begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(w_do_push);
            r_rd_ptr <= r_rd_ptr + PTR_W'(w_do_pop);
            r_count  <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_burst_ctrl.sv
// ============================================================================
//  Module   : mem_burst_ctrl
//  Purpose  : Burst read/write controller issuing single-word req/ack beats
//             to the storage backend, with write FIFO and ack timeout.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module mem_burst_ctrl
    import mem_burst_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int LEN_W      = DEF_LEN_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic              i_cmd_write,
    input  logic [ADDR_W-1:0] i_cmd_addr,
    input  logic [LEN_W-1:0]  i_cmd_len,
    input  logic              i_wdata_valid,
    output logic              o_wdata_ready,
    input  logic [DATA_W-1:0] i_wdata,
    output logic              o_rdata_valid,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_done,
    output logic              o_err,
    output logic              o_busy,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic              i_mem_ack,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    localparam int CNT_W = clog2(FIFO_DEPTH + 1);
    localparam int TMO_W = clog2(TIMEOUT + 2);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_rem;
    logic [TMO_W-1:0]  r_tmo;
    logic              r_mem_req;
    logic              r_mem_we;
    logic              r_rdata_valid;
    logic [DATA_W-1:0] r_rdata;
    logic              r_done;
    logic              r_err;
    logic              r_err_flag;

    logic              w_full;
    logic              w_empty;
    logic [DATA_W-1:0] w_head;
    logic [CNT_W-1:0]  w_count;
    logic [CNT_W-1:0]  w_cnt_after;
    logic              w_push;
    logic              w_pop;
    logic              w_ack;
    logic              w_tmo_hit;
    logic              w_abort;
    logic              w_req_next;

    sync_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_wfifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_tmo_hit),
        .i_data  (i_wdata),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign w_push    = i_wdata_valid && !w_full;
    assign w_ack     = r_mem_req && i_mem_ack;
    assign w_pop     = (r_state == ST_WRITE) && w_ack;
    // Occupancy the FIFO will have next cycle; decides whether a write beat follows.
    assign w_cnt_after = w_count + CNT_W'(w_push) - CNT_W'(w_pop);
    assign w_tmo_hit = (TIMEOUT != 0) && r_mem_req && !i_mem_ack &&
                       (r_tmo == TMO_W'(TIMEOUT - 1));

    assign o_cmd_ready   = (r_state == ST_IDLE);
    assign o_busy        = (r_state != ST_IDLE);
    assign o_wdata_ready = !w_full;
    assign o_mem_req     = r_mem_req;
    assign o_mem_we      = r_mem_we;
    assign o_mem_addr    = r_addr;
    assign o_mem_wdata   = r_mem_we ? w_head : '0;
    assign o_rdata_valid = r_rdata_valid;
    assign o_rdata       = r_rdata;
    assign o_done        = r_done;
    assign o_err         = r_err;
    // w_empty is implied by w_count; kept for readability of the FIFO interface.
    logic w_unused;
    assign w_unused = w_empty;

    always_comb begin
        w_next     = r_state;
        w_abort    = 1'b0;
        w_req_next = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_cmd_valid) begin
                    if (i_cmd_len == '0) begin
                        w_next  = ST_FINISH;
                        w_abort = 1'b1;
                    end else if (i_cmd_write) begin
                        w_next = ST_WRITE;
                    end else begin
                        w_next = ST_READ;
                    end
                end
            end
            ST_WRITE, ST_READ: begin
                if (w_tmo_hit) begin
                    w_next  = ST_FINISH;
                    w_abort = 1'b1;
                end else if (w_ack && (r_rem == LEN_W'(1))) begin
                    w_next = ST_FINISH;
                end
            end
            ST_FINISH: w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
        if (w_next == ST_READ) begin
            w_req_next = 1'b1;
        end else if (w_next == ST_WRITE) begin
            w_req_next = (w_cnt_after != '0);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_addr        <= '0;
            r_rem         <= '0;
            r_tmo         <= '0;
            r_mem_req     <= 1'b0;
            r_mem_we      <= 1'b0;
            r_rdata_valid <= 1'b0;
            r_rdata       <= '0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_err_flag    <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_mem_req <= w_req_next;
            r_mem_we  <= w_req_next && (w_next == ST_WRITE);

            if ((r_state == ST_IDLE) && i_cmd_valid) begin
                r_addr <= i_cmd_addr;
                r_rem  <= i_cmd_len;
            end else if (w_ack) begin
                r_addr <= r_addr + ADDR_W'(1);
                r_rem  <= r_rem - LEN_W'(1);
            end

            r_rdata_valid <= (r_state == ST_READ) && w_ack;
            if ((r_state == ST_READ) && w_ack) begin
                r_rdata <= i_mem_rdata;
            end

            r_done <= (r_state == ST_FINISH);
            r_err  <= (r_state == ST_FINISH) && r_err_flag;
            if ((w_next == ST_FINISH) && (r_state != ST_FINISH)) begin
                r_err_flag <= w_abort;
            end

            // Idle waits for write data leave r_mem_req low, so they never count.
            if (w_ack || (w_next != r_state)) begin
                r_tmo <= '0;
            end else if (r_mem_req && (TIMEOUT != 0)) begin
                r_tmo <= r_tmo + TMO_W'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_burst_ctrl.sv
// ============================================================================
//  Module   : tb_mem_burst_ctrl
//  Purpose  : Directed self-checking bench for mem_burst_ctrl (TIMEOUT=16).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_burst_ctrl;

    logic        clk;
    logic        reset_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [23:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic        wdata_valid, wdata_ready;
    logic [31:0] wdata;
    logic        rdata_valid;
    logic [31:0] rdata;
    logic        done, err, busy;
    logic        mem_req, mem_we;
    logic [23:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int errors = 0;
    int checks = 0;
    int ack_mode = 0;   // 0 never, 1 every cycle, 2 after two wait cycles

    logic [23:0] q_addr[$];
    logic [31:0] q_data[$];
    logic        q_we[$];
    logic [31:0] q_rd[$];

    mem_burst_ctrl #(
        .DATA_W(32), .ADDR_W(24), .LEN_W(8), .FIFO_DEPTH(16), .TIMEOUT(16)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_write(cmd_write),
        .i_cmd_addr(cmd_addr), .i_cmd_len(cmd_len),
        .i_wdata_valid(wdata_valid), .o_wdata_ready(wdata_ready), .i_wdata(wdata),
        .o_rdata_valid(rdata_valid), .o_rdata(rdata),
        .o_done(done), .o_err(err), .o_busy(busy),
        .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Backend model: decides ack at each falling edge and logs the beat that
    // the next rising edge will consume; read data equals the word address.
    initial begin : backend
        int wcnt;
        logic a;
        wcnt = 0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            a = 1'b0;
            if (mem_req) begin
                if (ack_mode == 1) begin
                    a = 1'b1;
                end else if (ack_mode == 2) begin
                    if (wcnt == 2) begin
                        a = 1'b1;
                        wcnt = 0;
                    end else begin
                        wcnt = wcnt + 1;
                    end
                end
            end else begin
                wcnt = 0;
            end
            mem_ack = a;
            mem_rdata = {8'h00, mem_addr};
            if (a) begin
                q_addr.push_back(mem_addr);
                q_data.push_back(mem_wdata);
                q_we.push_back(mem_we);
            end
            if (rdata_valid) q_rd.push_back(rdata);
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic clear_logs();
        q_addr.delete(); q_data.delete(); q_we.delete(); q_rd.delete();
    endtask

    task automatic issue(input logic wr, input logic [23:0] addr, input logic [7:0] len);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = len;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic push_words(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            wdata_valid = 1'b1;
            wdata = base + 32'(i);
        end
        @(negedge clk);
        wdata_valid = 1'b0;
    endtask

    task automatic wait_done(input int max, output bit got, output logic e, output logic rdy,
                             output int extra);
        got = 1'b0; e = 1'bx; rdy = 1'bx; extra = 0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1; e = err; rdy = cmd_ready;
                break;
            end
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) extra = extra + 1;
        end
    endtask

    // Write one word with len=1 and an empty FIFO: no beat may appear until the word is pushed.
    task automatic test_fifo_empty(input string tag, input logic [31:0] word);
        bit got; logic e, r; int extra;
        clear_logs();
        ack_mode = 1;
        issue(1'b1, 24'h000300, 8'd1);
        repeat (5) @(negedge clk);
        checks++;
        if (q_addr.size() !== 0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL %s_empty: beats=%0d req=%b required beats=0 req=0", tag, q_addr.size(), mem_req);
        end
        push_words(1, word);
        wait_done(20, got, e, r, extra);
        checks++;
        if (!got || q_data.size() != 1 || q_data[0] !== word) begin
            errors++;
            $display("FAIL %s_drain: done=%b beats=%0d required done=1 beats=1 data=%h", tag, got, q_data.size(), word);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #1;
        checks++;
        if ({mem_req, mem_we, busy, done, err, rdata_valid, cmd_ready, wdata_ready} !== 8'b0000_0011 ||
            mem_addr !== 24'h0 || mem_wdata !== 32'h0 || rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: req=%b we=%b busy=%b done=%b err=%b rv=%b crdy=%b wrdy=%b addr=%h wd=%h rd=%h required all 0 except ready=1",
                     mem_req, mem_we, busy, done, err, rdata_valid, cmd_ready, wdata_ready, mem_addr, mem_wdata, rdata);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        // Mid-burst reset: write stalled without ack, with two words prefetched.
        ack_mode = 0;
        push_words(2, 32'h0000_0F00);
        issue(1'b1, 24'h000020, 8'd4);
        repeat (3) @(negedge clk);
        checks++;
        if (mem_req !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre_burst: req=%b busy=%b required 1 1", mem_req, busy);
        end
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({mem_req, busy, cmd_ready, wdata_ready, done} !== 5'b00110) begin
            errors++;
            $display("FAIL reset_mid_burst: req=%b busy=%b crdy=%b wrdy=%b done=%b required 0 0 1 1 0",
                     mem_req, busy, cmd_ready, wdata_ready, done);
        end
        test_fifo_empty("reset", 32'h0000_0055);
    endtask

    task automatic test_prefetch_write();
        bit got; logic e, r; int extra; int bad;
        clear_logs();
        ack_mode = 1;
        push_words(4, 32'h0000_00A0);
        issue(1'b1, 24'h000010, 8'd4);
        wait_done(20, got, e, r, extra);
        bad = 0;
        for (int i = 0; i < q_addr.size(); i++)
            if (q_addr[i] !== 24'h10 + 24'(i) || q_data[i] !== 32'hA0 + 32'(i) || q_we[i] !== 1'b1) bad++;
        checks++;
        if (q_addr.size() != 4 || bad != 0) begin
            errors++;
            $display("FAIL write_beats: beats=%0d bad=%0d required beats=4 bad=0", q_addr.size(), bad);
        end
        checks++;
        if (!got || e !== 1'b0 || extra != 0) begin
            errors++;
            $display("FAIL write_done: done=%b err=%b extra=%0d required 1 0 0", got, e, extra);
        end
        test_fifo_empty("write", 32'h0000_00B0);
    endtask

    task automatic test_read_wrap();
        bit got; logic e, r; int extra;
        logic [23:0] ea [3];
        clear_logs();
        ack_mode = 1;
        ea[0] = 24'hFFFFFE; ea[1] = 24'hFFFFFF; ea[2] = 24'h000000;
        issue(1'b0, 24'hFFFFFE, 8'd3);
        wait_done(20, got, e, r, extra);
        checks++;
        if (q_addr.size() != 3 || q_addr[0] !== ea[0] || q_addr[1] !== ea[1] || q_addr[2] !== ea[2] ||
            q_we[0] !== 1'b0) begin
            errors++;
            $display("FAIL read_addr: beats=%0d required FFFFFE FFFFFF 000000 we=0", q_addr.size());
        end
        checks++;
        if (q_rd.size() != 3 || q_rd[0] !== 32'h00FFFFFE || q_rd[1] !== 32'h00FFFFFF || q_rd[2] !== 32'h0) begin
            errors++;
            $display("FAIL read_data: pulses=%0d required 3 pulses 00FFFFFE 00FFFFFF 00000000", q_rd.size());
        end
        checks++;
        if (!got || e !== 1'b0 || extra != 0) begin
            errors++;
            $display("FAIL read_done: done=%b err=%b extra=%0d required 1 0 0", got, e, extra);
        end
    endtask

    task automatic test_trickle_write();
        bit got; logic e, r; int extra;
        clear_logs();
        ack_mode = 2;
        issue(1'b1, 24'h000040, 8'd3);
        for (int k = 0; k < 3; k++) begin
            push_words(1, 32'h0000_00C0 + 32'(k));
            if (k < 2) repeat (3) @(negedge clk);
        end
        wait_done(40, got, e, r, extra);
        checks++;
        if (q_data.size() != 3 || q_data[0] !== 32'hC0 || q_data[1] !== 32'hC1 || q_data[2] !== 32'hC2 ||
            q_addr[2] !== 24'h42) begin
            errors++;
            $display("FAIL trickle_beats: acks=%0d required 3 acks C0 C1 C2", q_data.size());
        end
        checks++;
        if (!got || e !== 1'b0) begin
            errors++;
            $display("FAIL trickle_done: done=%b err=%b required 1 0", got, e);
        end
    endtask

    task automatic test_timeout();
        bit got; logic e, r; int extra; int cnt;
        clear_logs();
        ack_mode = 0;
        issue(1'b0, 24'h000500, 8'd2);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (!mem_req) break;
            cnt++;
            @(negedge clk);
        end
        checks++;
        if (cnt != 16) begin
            errors++;
            $display("FAIL timeout_req_cycles: got %0d required 16", cnt);
        end
        wait_done(5, got, e, r, extra);
        checks++;
        if (!got || e !== 1'b1 || r !== 1'b1 || q_rd.size() != 0) begin
            errors++;
            $display("FAIL timeout_done: done=%b err=%b crdy=%b rdata=%0d required 1 1 1 0", got, e, r, q_rd.size());
        end
    endtask

    task automatic test_zero_len();
        clear_logs();
        ack_mode = 1;
        issue(1'b1, 24'h000600, 8'd0);
        checks++;
        if (mem_req !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL zero_len_c1: req=%b done=%b busy=%b required 0 0 1", mem_req, done, busy);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || err !== 1'b1 || mem_req !== 1'b0 || q_addr.size() != 0) begin
            errors++;
            $display("FAIL zero_len_c2: done=%b err=%b req=%b beats=%0d required 1 1 0 0", done, err, mem_req, q_addr.size());
        end
    endtask

    task automatic test_back_to_back();
        bit got; logic e, r; int extra;
        clear_logs();
        ack_mode = 1;
        push_words(2, 32'h0000_00E0);
        issue(1'b1, 24'h000090, 8'd3);
        wdata_valid = 1'b1;
        wdata = 32'h0000_00E2;
        @(negedge clk);
        wdata_valid = 1'b0;
        wait_done(20, got, e, r, extra);
        checks++;
        if (!got || q_data.size() != 3 || q_data[0] !== 32'hE0 || q_data[1] !== 32'hE1 || q_data[2] !== 32'hE2) begin
            errors++;
            $display("FAIL push_pop: done=%b beats=%0d required done=1 E0 E1 E2", got, q_data.size());
        end
        test_fifo_empty("push_pop", 32'h0000_00E9);
    endtask

    task automatic test_fifo_full();
        bit got; logic e, r; int extra; int bad;
        clear_logs();
        ack_mode = 1;
        push_words(16, 32'h0000_0D00);
        checks++;
        if (wdata_ready !== 1'b0) begin
            errors++;
            $display("FAIL fifo_full_ready: got %b required 0", wdata_ready);
        end
        issue(1'b1, 24'h000080, 8'd16);
        wait_done(40, got, e, r, extra);
        bad = 0;
        for (int i = 0; i < q_data.size(); i++)
            if (q_data[i] !== 32'hD00 + 32'(i)) bad++;
        checks++;
        if (!got || q_data.size() != 16 || bad != 0 || wdata_ready !== 1'b1) begin
            errors++;
            $display("FAIL fifo_full_drain: done=%b beats=%0d bad=%0d wrdy=%b required 1 16 0 1",
                     got, q_data.size(), bad, wdata_ready);
        end
    endtask

    initial begin
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        wdata_valid = 1'b0; wdata = '0;
        test_reset();
        test_prefetch_write();
        test_read_wrap();
        test_trickle_write();
        test_timeout();
        test_zero_len();
        test_back_to_back();
        test_fifo_full();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
